flappy_game_ctrl: RTL and testbench

//  Game sequencer for FlappyBird: owns game state (pre-game/play/flash/over) and bird vertical physics.

---
 rtl/flappy_game_ctrl_pkg.sv | 25 ++
 rtl/flappy_game_ctrl_bird_physics.sv | 82 ++++++++
 rtl/flappy_game_ctrl.sv | 162 ++++++++++++++++
 tb/tb_flappy_game_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flappy_game_ctrl_pkg.sv
// flappy_game_ctrl_pkg
//   Shared constants and types for the FlappyBird game sequencer.
//   - game_state_t : top-level game state (pre-game, play, flash, over)
//   - SCREEN_HEIGHT: visible rows; the default bottom limit for the bird
//   - RED / YELLOW : 24-bit {r,g,b} game-over colours
//   - sat_inc8     : saturating 8-bit increment used for the score
package flappy_game_ctrl_pkg;

  typedef enum logic [1:0] {
    S_PRE   = 2'd0,
    S_PLAY  = 2'd1,
    S_FLASH = 2'd2,
    S_OVER  = 2'd3
  } game_state_t;

  localparam int SCREEN_HEIGHT = 240;

  localparam logic [23:0] RED    = 24'hFF0000;
  localparam logic [23:0] YELLOW = 24'hFFFF00;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/flappy_game_ctrl_bird_physics.sv
// flappy_game_ctrl_bird_physics
//   Bird vertical motion: velocity and top-row registers, gravity with a
//   downward velocity clamp, flap impulse, and clamping of the bird to the
//   legal row range.
// Ports
//   clk, reset   : clock, synchronous active-high reset
//   reload       : hold the bird at its start row with zero velocity
//   step         : advance one frame (frame tick while playing)
//   flap_load    : on this step load the upward flap velocity instead of gravity
//   birdTop/Bot  : registered bird bounds, stable between steps
//   hit          : combinational; this step clamped the bird against a screen edge
module flappy_game_ctrl_bird_physics #(
  parameter int BIRD_Y0 = 100,
  parameter int BIRD_H  = 12,
  parameter int Y_MIN   = 0,
  parameter int Y_MAX   = 239,
  parameter int GRAVITY = 1,
  parameter int FLAP_V  = 6,
  parameter int V_MAX   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reload,
  input  logic       step,
  input  logic       flap_load,
  output logic [8:0] birdTop,
  output logic [8:0] birdBot,
  output logic       hit
);

  localparam logic signed [7:0]  VEL_FLAP = 8'(-FLAP_V);
  localparam logic signed [7:0]  VEL_G    = 8'(GRAVITY);
  localparam logic signed [7:0]  VEL_MAX  = 8'(V_MAX);
  localparam logic signed [10:0] H_M1_S   = 11'(BIRD_H - 1);
  localparam logic signed [10:0] YMIN_S   = 11'(Y_MIN);
  localparam logic signed [10:0] YMAX_S   = 11'(Y_MAX);

  logic signed [7:0]  vel_reg;
  logic signed [7:0]  vel_inc;
  logic signed [7:0]  vel_next;
  logic signed [10:0] ny;
  logic signed [10:0] nbot;
  logic [8:0]         top_reg;
  logic [8:0]         bot_reg;
  logic [8:0]         top_next;
  logic               clamp;

  always_comb begin
    vel_inc  = vel_reg + VEL_G;
    vel_next = flap_load ? VEL_FLAP : ((vel_inc > VEL_MAX) ? VEL_MAX : vel_inc);
    // Signed 11-bit arithmetic so an upward move past row 0 shows up as negative.
    ny       = $signed({2'b00, top_reg}) + $signed({{3{vel_next[7]}}, vel_next});
    nbot     = ny + H_M1_S;
    clamp    = 1'b0;
    top_next = ny[8:0];
    if (ny < YMIN_S) begin
      top_next = 9'(Y_MIN);
      clamp    = 1'b1;
    end else if (nbot > YMAX_S) begin
      top_next = 9'(Y_MAX - BIRD_H + 1);
      clamp    = 1'b1;
    end
  end

  assign hit = step & clamp;

  always_ff @(posedge clk) begin
    if (reset || reload) begin
      vel_reg <= '0;
      top_reg <= 9'(BIRD_Y0);
      bot_reg <= 9'(BIRD_Y0 + BIRD_H - 1);
    end else if (step) begin
      vel_reg <= vel_next;
      top_reg <= top_next;
      bot_reg <= top_next + 9'(BIRD_H - 1);
    end
  end

  assign birdTop = top_reg;
  assign birdBot = bot_reg;

endmodule

// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl
//   Game sequencer for FlappyBird: game state machine, frame divider,
//   death-flash timing, score and bird physics (sub-module).
// Ports
//   clk, reset           : clock, synchronous active-high reset
//   flap                 : synchronised button level, rising edge = flap/start/restart
//   collision            : bird/pipe overlap level
//   pipe_passed          : one-clock pulse per pipe cleared
//   birdTop, birdBot     : bird bounds (9 bit rows)
//   obs_step             : one-clock pulse per frame while playing
//   dead                 : high in FLASH and OVER
//   go_r, go_g, go_b     : game-over colour
//   score                : pipes passed, saturating at 255
//   state                : current game state
module flappy_game_ctrl
  import flappy_game_ctrl_pkg::*;
#(
  parameter int FRAME_DIV    = 833333,
  parameter int BIRD_Y0      = 100,
  parameter int BIRD_H       = 12,
  parameter int Y_MIN        = 0,
  parameter int Y_MAX        = SCREEN_HEIGHT - 1,
  parameter int GRAVITY      = 1,
  parameter int FLAP_V       = 6,
  parameter int V_MAX        = 8,
  parameter int FLASH_FRAMES = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flap,
  input  logic        collision,
  input  logic        pipe_passed,
  output logic [8:0]  birdTop,
  output logic [8:0]  birdBot,
  output logic        obs_step,
  output logic        dead,
  output logic [7:0]  go_r,
  output logic [7:0]  go_g,
  output logic [7:0]  go_b,
  output logic [7:0]  score,
  output game_state_t state
);

  logic [31:0] frame_cnt_reg;
  logic [15:0] flash_cnt_reg;
  logic        flap_q_reg;
  logic        flap_pend_reg;
  logic        obs_step_reg;
  logic        dead_reg;
  logic [7:0]  score_reg;
  logic [23:0] go_reg;
  game_state_t state_reg;

  logic tick;
  logic flap_edge;
  logic phys_step;
  logic phys_reload;
  logic hit;

  assign tick      = (frame_cnt_reg == 32'(FRAME_DIV - 1));
  assign flap_edge = flap & ~flap_q_reg;

  // A same-cycle collision wins over the frame update, so no velocity load happens.
  assign phys_step   = tick & (state_reg == S_PLAY) & ~collision;
  // Bird is pinned at its start row in PRE and reloaded on the restart edge itself.
  assign phys_reload = (state_reg == S_PRE) | ((state_reg == S_OVER) & flap_edge);

  flappy_game_ctrl_bird_physics #(
    .BIRD_Y0 (BIRD_Y0),
    .BIRD_H  (BIRD_H),
    .Y_MIN   (Y_MIN),
    .Y_MAX   (Y_MAX),
    .GRAVITY (GRAVITY),
    .FLAP_V  (FLAP_V),
    .V_MAX   (V_MAX)
  ) u_bird_physics (
    .clk       (clk),
    .reset     (reset),
    .reload    (phys_reload),
    .step      (phys_step),
    .flap_load (flap_pend_reg),
    .birdTop   (birdTop),
    .birdBot   (birdBot),
    .hit       (hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_reg <= '0;
      flash_cnt_reg <= '0;
      flap_q_reg    <= 1'b0;
      flap_pend_reg <= 1'b0;
      obs_step_reg  <= 1'b0;
      dead_reg      <= 1'b0;
      score_reg     <= '0;
      go_reg        <= RED;
      state_reg     <= S_PRE;
    end else begin
      flap_q_reg    <= flap;
      frame_cnt_reg <= tick ? '0 : frame_cnt_reg + 32'd1;
      obs_step_reg  <= tick & (state_reg == S_PLAY);

      case (state_reg)
        S_PRE: begin
          if (flap_edge) begin
            state_reg     <= S_PLAY;
            score_reg     <= '0;
            // The starting press also counts as the first flap.
            flap_pend_reg <= 1'b1;
          end
        end

        S_PLAY: begin
          if (collision || hit) begin
            state_reg     <= S_FLASH;
            flash_cnt_reg <= '0;
            dead_reg      <= 1'b1;
            go_reg        <= RED;
            flap_pend_reg <= 1'b0;
          end else begin
            if (pipe_passed) score_reg <= sat_inc8(score_reg);
            // The tick consumes the pending flap; an edge on the tick itself
            // is kept for the following frame.
            if (tick)           flap_pend_reg <= flap_edge;
            else if (flap_edge) flap_pend_reg <= 1'b1;
          end
        end

        S_FLASH: begin
          if (tick) begin
            if (flash_cnt_reg == 16'(FLASH_FRAMES - 1)) begin
              state_reg <= S_OVER;
              go_reg    <= RED;
            end else begin
              flash_cnt_reg <= flash_cnt_reg + 16'd1;
              go_reg        <= (go_reg == RED) ? YELLOW : RED;
            end
          end
        end

        S_OVER: begin
          if (flap_edge) begin
            state_reg <= S_PRE;
            dead_reg  <= 1'b0;
            go_reg    <= RED;
          end
        end

        default: state_reg <= S_PRE;
      endcase
    end
  end

  assign obs_step = obs_step_reg;
  assign dead     = dead_reg;
  assign score    = score_reg;
  assign state    = state_reg;
  assign go_r     = go_reg[23:16];
  assign go_g     = go_reg[15:8];
  assign go_b     = go_reg[7:0];

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// tb_flappy_game_ctrl
//   Self-checking bench for flappy_game_ctrl with FRAME_DIV=4.
//   A table of input/expected records is applied one per clock through a
//   scoreboard queue; the bird trajectory is predicted into a queue and popped
//   on each obs_step pulse; hand-written sequences cover flash timing,
//   restart, score saturation and mid-game reset.
module tb_flappy_game_ctrl;
  import flappy_game_ctrl_pkg::*;

  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flap = 1'b0;
  logic        collision = 1'b0;
  logic        pipe_passed = 1'b0;
  logic [8:0]  birdTop;
  logic [8:0]  birdBot;
  logic        obs_step;
  logic        dead;
  logic [7:0]  go_r;
  logic [7:0]  go_g;
  logic [7:0]  go_b;
  logic [7:0]  score;
  game_state_t state;

  flappy_game_ctrl #(.FRAME_DIV(FD)) dut (
    .clk         (clk),
    .reset       (reset),
    .flap        (flap),
    .collision   (collision),
    .pipe_passed (pipe_passed),
    .birdTop     (birdTop),
    .birdBot     (birdBot),
    .obs_step    (obs_step),
    .dead        (dead),
    .go_r        (go_r),
    .go_g        (go_g),
    .go_b        (go_b),
    .score       (score),
    .state       (state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Independent frame-tick model: tick_seen is high at the negedge after a tick edge.
  int m_cnt = 0;
  bit tick_seen = 1'b0;
  always @(posedge clk) begin
    if (reset) begin
      m_cnt     <= 0;
      tick_seen <= 1'b0;
    end else begin
      m_cnt     <= (m_cnt == FD - 1) ? 0 : m_cnt + 1;
      tick_seen <= (m_cnt == FD - 1);
    end
  end

  typedef struct {
    int          idx;
    bit          flap;
    bit          col;
    bit          pipe;
    bit          rst;
    game_state_t st;
    int          score;
    bit          dead;
  } vec_t;

  vec_t tbl[12];
  vec_t pend_q[$];
  int   exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  function automatic int go_rgb();
    return int'({go_r, go_g, go_b});
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, " state"},    int'(state), int'(S_PRE));
    check({tag, " birdTop"},  int'(birdTop), 100);
    check({tag, " birdBot"},  int'(birdBot), 111);
    check({tag, " score"},    int'(score), 0);
    check({tag, " dead"},     int'(dead), 0);
    check({tag, " obs_step"}, int'(obs_step), 0);
    check({tag, " go"},       go_rgb(), int'(RED));
  endtask

  task automatic check_vec(input vec_t v);
    check($sformatf("vec%0d state", v.idx), int'(state), int'(v.st));
    check($sformatf("vec%0d score", v.idx), int'(score), v.score);
    check($sformatf("vec%0d dead", v.idx),  int'(dead), int'(v.dead));
  endtask

  // Expected birdTop after each frame from game start (first frame uses the start flap).
  task automatic gen_traj(input bit flap_every);
    int top;
    int v;
    top = 100;
    v   = -6;
    exp_q.delete();
    for (int k = 0; k < 200; k++) begin
      top = top + v;
      if (top < 0) begin
        exp_q.push_back(0);
        break;
      end
      if (top + 11 > 239) begin
        exp_q.push_back(228);
        break;
      end
      exp_q.push_back(top);
      v = flap_every ? -6 : ((v + 1 > 8) ? 8 : v + 1);
    end
  endtask

  // Called at a negedge in S_PRE; plays until the predicted clamp/hit frame.
  task automatic run_traj(input bit flap_every, input bit pipes, input string tag);
    int last;
    int e;
    bit ob;
    gen_traj(flap_every);
    last = -1;
    flap = 1'b1;
    for (int c = 0; c < 400 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      ob = obs_step;
      if (c == 0) begin
        check({tag, " start state"}, int'(state), int'(S_PLAY));
        check({tag, " start score"}, int'(score), 0);
      end
      if (ob) begin
        e = exp_q.pop_front();
        check($sformatf("%s birdTop", tag), int'(birdTop), e);
        check($sformatf("%s birdBot", tag), int'(birdBot), e + 11);
        if (last >= 0) check({tag, " obs_step spacing"}, c - last, FD);
        last = c;
      end
      flap        = flap_every && ob && (exp_q.size() > 0);
      pipe_passed = pipes && (c < 3);
    end
    flap        = 1'b0;
    pipe_passed = 1'b0;
    check({tag, " frames left"}, exp_q.size(), 0);
    check({tag, " hit state"},   int'(state), int'(S_FLASH));
    check({tag, " hit dead"},    int'(dead), 1);
  endtask

  // Called at the negedge where the state has just become S_FLASH.
  task automatic run_flash();
    int n;
    n = 0;
    for (int c = 0; c < 400 && n < 30; c++) begin
      @(negedge clk);
      flap = (c == 6);
      if (tick_seen) begin
        n++;
        check($sformatf("flash go t%0d", n), go_rgb(),
              int'((n < 30 && (n % 2 == 1)) ? YELLOW : RED));
        check($sformatf("flash state t%0d", n), int'(state),
              int'((n < 30) ? S_FLASH : S_OVER));
      end
    end
    flap = 1'b0;
    check("flash ticks", n, 30);
    check("over dead", int'(dead), 1);
    repeat (8) @(negedge clk);
    check("no queued restart", int'(state), int'(S_OVER));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ob_cnt;

    // Table: applied one row per clock, checked on the following negedge.
    tbl[0]  = '{0,  1, 0, 0, 0, S_PLAY,  0, 0};
    tbl[1]  = '{1,  1, 0, 1, 0, S_PLAY,  1, 0};
    tbl[2]  = '{2,  0, 0, 1, 0, S_PLAY,  2, 0};
    tbl[3]  = '{3,  0, 0, 0, 0, S_PLAY,  2, 0};
    tbl[4]  = '{4,  0, 0, 1, 0, S_PLAY,  3, 0};
    tbl[5]  = '{5,  1, 1, 1, 0, S_FLASH, 3, 1};
    tbl[6]  = '{6,  0, 0, 1, 0, S_FLASH, 3, 1};
    tbl[7]  = '{7,  1, 0, 0, 0, S_FLASH, 3, 1};
    tbl[8]  = '{8,  0, 0, 0, 1, S_PRE,   0, 0};
    tbl[9]  = '{9,  1, 0, 0, 0, S_PLAY,  0, 0};
    tbl[10] = '{10, 1, 1, 0, 0, S_FLASH, 0, 1};
    tbl[11] = '{11, 0, 0, 0, 1, S_PRE,   0, 0};

    // 1: reset, then idle in pre-game
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    ob_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (obs_step) ob_cnt++;
    end
    check("idle obs_step count", ob_cnt, 0);
    check("idle state", int'(state), int'(S_PRE));
    check("idle birdTop", int'(birdTop), 100);
    check("idle birdBot", int'(birdBot), 111);

    // 4/6: score, collision priority, ignored inputs, resets (table-driven)
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (pend_q.size() > 0) check_vec(pend_q.pop_front());
      flap        = tbl[i].flap;
      collision   = tbl[i].col;
      pipe_passed = tbl[i].pipe;
      reset       = tbl[i].rst;
      pend_q.push_back(tbl[i]);
    end
    @(negedge clk);
    check_vec(pend_q.pop_front());
    flap = 1'b0; collision = 1'b0; pipe_passed = 1'b0; reset = 1'b0;
    @(negedge clk);

    // 2/3: free fall to the floor clamp with three pipes passed
    run_traj(1'b0, 1'b1, "fall");
    check("fall score", int'(score), 3);
    run_flash();

    // 5: restart from game over keeps the score until the next start
    flap = 1'b1;
    @(negedge clk);
    check("restart state",   int'(state), int'(S_PRE));
    check("restart birdTop", int'(birdTop), 100);
    check("restart birdBot", int'(birdBot), 111);
    check("restart score",   int'(score), 3);
    check("restart dead",    int'(dead), 0);
    flap = 1'b0;
    @(negedge clk);

    // Flap every frame: climb into the ceiling clamp
    run_traj(1'b1, 1'b0, "climb");
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("reset mid-FLASH");
    reset = 1'b0;
    @(negedge clk);

    // Score saturation while keeping the bird aloft
    flap = 1'b1;
    @(negedge clk);
    flap = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      pipe_passed = 1'b1;
      flap        = obs_step && (birdTop >= 9'd110);
    end
    @(negedge clk);
    pipe_passed = 1'b0;
    flap        = 1'b0;
    @(negedge clk);
    check("saturated score", int'(score), 255);
    check("saturation state", int'(state), int'(S_PLAY));
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("reset mid-PLAY");
    reset = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
